ctrl_decode_pipe: RTL

CTRL_DECODE_PIPE -- requirements
Module: ctrl_decode_pipe

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/ctrl_decode_comb.sv | 96 +++++++++
 rtl/ctrl_decode_pipe.sv | 91 +++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_pkg
// Brief    : Shared opcode, u_control and funct7 encodings, the packed control
//            word and the decode-pipe state type.
// Revision : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_auipc  = 7'b0010111;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_opimm  = 7'b0010011;
    localparam logic [6:0] c_op_op     = 7'b0110011;

    localparam logic [1:0] c_u_none  = 2'b00;
    localparam logic [1:0] c_u_lui   = 2'b01;
    localparam logic [1:0] c_u_auipc = 2'b10;

    localparam logic [6:0] c_f7_base   = 7'b0000000;
    localparam logic [6:0] c_f7_alt    = 7'b0100000;
    localparam logic [6:0] c_f7_muldiv = 7'b0000001;

    typedef struct packed {
        logic [1:0] u_control;
        logic       reg_write;
        logic       alu_src_imm;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic       muldiv;
    } ctrl_t;

    typedef enum logic [0:0] {
        RUN  = 1'b0,
        TRAP = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ctrl_decode_comb.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode_comb
// Brief    : Pure combinational RV32I instr -> {ctrl_t, illegal} decode.
//            Macro RV_M_EXT_EN accepts the M-extension OP encoding (muldiv).
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode_comb
    import ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output logic [9:0]  ctrl,
    output logic        illegal
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;
    ctrl_t      w_ctrl;
    logic       w_illegal;
    logic       w_unused;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_unused = ^{instr[24:15], instr[11:7]};

    always_comb begin
        w_ctrl           = '0;
        w_ctrl.u_control = c_u_none;
        w_illegal        = 1'b0;
        case (w_opcode)
            c_op_lui: begin
                w_ctrl.u_control = c_u_lui;
                w_ctrl.reg_write = 1'b1;
            end
            c_op_auipc: begin
                w_ctrl.u_control = c_u_auipc;
                w_ctrl.reg_write = 1'b1;
            end
            c_op_jal: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.jump      = 1'b1;
            end
            c_op_jalr: begin
                if (w_funct3 == 3'b000) begin
                    w_ctrl.reg_write   = 1'b1;
                    w_ctrl.jump        = 1'b1;
                    w_ctrl.jalr        = 1'b1;
                    w_ctrl.alu_src_imm = 1'b1;
                end else begin
                    w_illegal = 1'b1;
                end
            end
            c_op_branch: w_ctrl.branch = 1'b1;
            c_op_load: begin
                w_ctrl.mem_read    = 1'b1;
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
            end
            c_op_store: begin
                w_ctrl.mem_write   = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
            end
            c_op_opimm: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src_imm = 1'b1;
            end
            c_op_op: begin
                if (w_funct7 == c_f7_base || w_funct7 == c_f7_alt) begin
                    w_ctrl.reg_write = 1'b1;
`ifdef RV_M_EXT_EN
                end else if (w_funct7 == c_f7_muldiv) begin
                    w_ctrl.reg_write = 1'b1;
                    w_ctrl.muldiv    = 1'b1;
`else
                // Without the M extension its encoding is just another bad funct7
                end else if (w_funct7 == c_f7_muldiv) begin
                    w_illegal = 1'b1;
`endif
                end else begin
                    w_illegal = 1'b1;
                end
            end
            default: w_illegal = 1'b1;
        endcase
        if (w_illegal) begin
            w_ctrl = '0;
        end
    end

    assign ctrl    = w_ctrl;
    assign illegal = w_illegal;

endmodule
`default_nettype wire

// File: rtl/ctrl_decode_pipe.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_decode_pipe
// Brief    : One-stage valid/ready decode register with illegal-instruction
//            trap and saturating counter. Macro RV_M_EXT_EN enables muldiv.
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_decode_pipe
    import ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    input  logic [ADDR_W-1:0] in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_pc,
    output logic [9:0]        out_ctrl,
    output logic              trap,
    input  logic              trap_ack,
    output logic [CNT_W-1:0]  illegal_cnt
);

    state_t            r_state;
    logic              r_out_valid;
    logic [ADDR_W-1:0] r_out_pc;
    logic [9:0]        r_out_ctrl;
    logic [CNT_W-1:0]  r_illegal_cnt;

    logic [9:0]        w_dec_ctrl;
    logic              w_dec_illegal;
    logic              w_in_fire;
    logic              w_out_fire;

    ctrl_decode_comb u_decode (
        .instr   (instr),
        .ctrl    (w_dec_ctrl),
        .illegal (w_dec_illegal)
    );

    assign in_ready   = (r_state == RUN) & (~r_out_valid | out_ready) & ~rst;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= RUN;
            r_out_valid   <= 1'b0;
            r_out_pc      <= '0;
            r_out_ctrl    <= '0;
            r_illegal_cnt <= '0;
        end else if (flush) begin
            r_state     <= RUN;
            r_out_valid <= 1'b0;
        end else begin
            // An illegal word never reaches the output; the held entry may still drain
            if (w_in_fire && w_dec_illegal) begin
                r_state <= TRAP;
                if (r_illegal_cnt != '1) begin
                    r_illegal_cnt <= r_illegal_cnt + CNT_W'(1);
                end
                if (w_out_fire) begin
                    r_out_valid <= 1'b0;
                end
            end else if (w_in_fire) begin
                r_out_valid <= 1'b1;
                r_out_pc    <= in_pc;
                r_out_ctrl  <= w_dec_ctrl;
            end else if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end
            if (r_state == TRAP && trap_ack) begin
                r_state <= RUN;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_pc      = r_out_pc;
    assign out_ctrl    = r_out_ctrl;
    assign trap        = (r_state == TRAP);
    assign illegal_cnt = r_illegal_cnt;

endmodule
`default_nettype wire
